// File: rtl/mem_io_pkg.sv
// rtl/mem_io_pkg.sv - shared region codes, timer register map and timer state enum
package mem_io_pkg;

    localparam logic [3:0] REGION_RAM   = 4'h0;
    localparam logic [3:0] REGION_LED   = 4'h1;
    localparam logic [3:0] REGION_TIMER = 4'h2;
    localparam logic [3:0] REGION_SW    = 4'h3;

    localparam logic [11:0] TMR_COUNT_OFS = 12'h000;
    localparam logic [11:0] TMR_CTRL_OFS  = 12'h001;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_AUTO_BIT = 1;
    localparam int CTRL_EXP_BIT  = 15;

    typedef enum logic [1:0] {
        TMR_IDLE = 2'd0,
        TMR_RUN  = 2'd1,
        TMR_STOP = 2'd2
    } tmr_state_t;

    function automatic logic [15:0] ctrl_word(input logic exp_flag, input logic auto_rl,
                                              input logic en);
        logic [15:0] w;
        w                = '0;
        w[CTRL_EXP_BIT]  = exp_flag;
        w[CTRL_AUTO_BIT] = auto_rl;
        w[CTRL_EN_BIT]   = en;
        return w;
    endfunction

endpackage

// File: rtl/io_timer.sv
// rtl/io_timer.sv - down-counting timer with reload, sticky expiry flag; built under MEM_IO_RESPONDER_TIMER_EN
module io_timer
    import mem_io_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_wr,
    input  logic        ctrl_wr,
    input  logic [15:0] wdata,
    output logic [15:0] count,
    output logic [15:0] ctrl,
    output logic        irq
);

    tmr_state_t  state;
    tmr_state_t  state_n;
    logic [15:0] reload;
    logic [15:0] count_n;
    logic        en;
    logic        auto_rl;
    logic        exp_flag;
    logic        expire;

    assign expire = (state == TMR_RUN) && (count == 16'd0);
    assign ctrl   = ctrl_word(exp_flag, auto_rl, en);
    assign irq    = exp_flag;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= TMR_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            TMR_IDLE: begin
                if (ctrl_wr && wdata[CTRL_EN_BIT]) begin
                    state_n = TMR_RUN;
                end
            end
            TMR_RUN: begin
                if (ctrl_wr && !wdata[CTRL_EN_BIT]) begin
                    state_n = TMR_IDLE;
                end else if (expire && !auto_rl && !count_wr) begin
                    state_n = TMR_STOP;
                end
            end
            TMR_STOP: begin
                // EN is necessarily set while stopped, so a COUNT write restarts
                if (ctrl_wr && !wdata[CTRL_EN_BIT]) begin
                    state_n = TMR_IDLE;
                end else if (count_wr) begin
                    state_n = TMR_RUN;
                end
            end
            default: state_n = TMR_IDLE;
        endcase
    end

    always_comb begin
        count_n = count;
        if (count_wr) begin
            count_n = wdata;
        end else if (state == TMR_RUN) begin
            if (count != 16'd0) begin
                count_n = count - 16'd1;
            end else if (auto_rl) begin
                count_n = reload;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count    <= '0;
            reload   <= '0;
            en       <= 1'b0;
            auto_rl  <= 1'b0;
            exp_flag <= 1'b0;
        end else begin
            count <= count_n;
            if (count_wr) begin
                reload <= wdata;
            end
            if (ctrl_wr) begin
                en      <= wdata[CTRL_EN_BIT];
                auto_rl <= wdata[CTRL_AUTO_BIT];
            end
            // an expiry in the same cycle beats a software clear
            if (expire) begin
                exp_flag <= 1'b1;
            end else if (ctrl_wr && wdata[CTRL_EXP_BIT]) begin
                exp_flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - memory-mapped RAM/LED/switch responder; timer included with MEM_IO_RESPONDER_TIMER_EN
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int RAM_AW = 7,
    parameter int LED_W  = 10
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [15:0]      addr,
    input  logic [15:0]      dout,
    input  logic             wren,
    input  logic [9:0]       SW,
    output logic [15:0]      DIN,
    output logic [LED_W-1:0] LEDR,
    output logic             irq
);

    logic [3:0]        region;
    logic [RAM_AW-1:0] ram_idx;
    logic [15:0]       ram [0:(1<<RAM_AW)-1];
    logic [15:0]       ram_q;
    logic [15:0]       tmr_rdata;
    logic [15:0]       rd_data;
    logic              unused_bits;

    assign region      = addr[15:12];
    assign ram_idx     = addr[RAM_AW-1:0];
    assign ram_q       = ram[ram_idx];
    assign unused_bits = ^{addr[11:RAM_AW], dout[15:LED_W]};

    // RAM contents survive reset; read-first falls out of DIN sampling ram_q
    always_ff @(posedge Clock) begin
        if (wren && region == REGION_RAM) begin
            ram[ram_idx] <= dout;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            LEDR <= '0;
        end else if (wren && region == REGION_LED) begin
            LEDR <= dout[LED_W-1:0];
        end
    end

`ifdef MEM_IO_RESPONDER_TIMER_EN
    logic        tmr_count_wr;
    logic        tmr_ctrl_wr;
    logic [15:0] tmr_count;
    logic [15:0] tmr_ctrl;

    assign tmr_count_wr = wren && region == REGION_TIMER && addr[11:0] == TMR_COUNT_OFS;
    assign tmr_ctrl_wr  = wren && region == REGION_TIMER && addr[11:0] == TMR_CTRL_OFS;

    io_timer u_timer (
        .clk      (Clock),
        .resetn   (Resetn),
        .count_wr (tmr_count_wr),
        .ctrl_wr  (tmr_ctrl_wr),
        .wdata    (dout),
        .count    (tmr_count),
        .ctrl     (tmr_ctrl),
        .irq      (irq)
    );

    always_comb begin
        tmr_rdata = '0;
        if (addr[11:0] == TMR_COUNT_OFS) begin
            tmr_rdata = tmr_count;
        end else if (addr[11:0] == TMR_CTRL_OFS) begin
            tmr_rdata = tmr_ctrl;
        end
    end
`else
    assign tmr_rdata = '0;
    assign irq       = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        case (region)
            REGION_RAM:   rd_data = ram_q;
            REGION_LED:   rd_data = 16'(LEDR);
            REGION_TIMER: rd_data = tmr_rdata;
            REGION_SW:    rd_data = {6'b0, SW};
            default:      rd_data = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            DIN <= '0;
        end else begin
            DIN <= rd_data;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - directed and randomized self-checking bench for mem_io_responder
module tb_mem_io_responder;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] dout = '0;
    logic        wren = 1'b0;
    logic [9:0]  SW = '0;
    logic [15:0] DIN;
    logic [9:0]  LEDR;
    logic        irq;

    int n_cmp = 0;
    int n_fail = 0;

    mem_io_responder #(.RAM_AW(7), .LED_W(10)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .addr   (addr),
        .dout   (dout),
        .wren   (wren),
        .SW     (SW),
        .DIN    (DIN),
        .LEDR   (LEDR),
        .irq    (irq)
    );

    always #5 Clock = ~Clock;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_STOP = 2;

    logic [15:0] m_mem [128];
    bit          m_vld [128];
    logic [9:0]  m_led = '0;
    logic [15:0] m_count = '0;
    logic [15:0] m_reload = '0;
    logic        m_en = 1'b0;
    logic        m_auto = 1'b0;
    logic        m_exp = 1'b0;
    int          m_state = S_IDLE;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // bit 16 flags whether the expected read value is known
    function automatic logic [16:0] model_read(input logic [15:0] a);
        case (a[15:12])
            4'h0: return {m_vld[a[6:0]], m_mem[a[6:0]]};
            4'h1: return {1'b1, 6'b0, m_led};
            4'h3: return {1'b1, 6'b0, SW};
`ifdef MEM_IO_RESPONDER_TIMER_EN
            4'h2: begin
                if (a[11:0] == 12'h000) return {1'b1, m_count};
                if (a[11:0] == 12'h001) return {1'b1, m_exp, 13'b0, m_auto, m_en};
                return 17'h10000;
            end
`endif
            default: return 17'h10000;
        endcase
    endfunction

    task automatic model_update(input logic [15:0] a, input logic [15:0] d, input logic w,
                                input logic r);
`ifdef MEM_IO_RESPONDER_TIMER_EN
        logic        cw;
        logic        tw;
        logic        ex;
        logic [15:0] nc;
        logic [15:0] nr;
        logic        ne;
        logic        na;
        logic        nx;
        int          ns;
`endif
        if (!r) begin
            m_led = '0; m_count = '0; m_reload = '0;
            m_en = 1'b0; m_auto = 1'b0; m_exp = 1'b0; m_state = S_IDLE;
            return;
        end
        if (w && a[15:12] == 4'h0) begin
            m_mem[a[6:0]] = d;
            m_vld[a[6:0]] = 1'b1;
        end
        if (w && a[15:12] == 4'h1) m_led = d[9:0];
`ifdef MEM_IO_RESPONDER_TIMER_EN
        cw = w && a == 16'h2000;
        tw = w && a == 16'h2001;
        nc = m_count; nr = m_reload; ne = m_en; na = m_auto; nx = m_exp; ns = m_state; ex = 1'b0;
        if (m_state == S_RUN) begin
            if (m_count != 0) nc = m_count - 16'd1;
            else begin
                ex = 1'b1;
                if (m_auto) nc = m_reload;
                else ns = S_STOP;
            end
        end
        if (cw) begin
            nc = d; nr = d;
            if (m_en) ns = S_RUN;
        end
        if (tw) begin
            ne = d[0]; na = d[1];
            if (d[15]) nx = 1'b0;
            if (!d[0]) ns = S_IDLE;
            else if (m_state == S_IDLE) ns = S_RUN;
        end
        if (ex) nx = 1'b1;
        m_count = nc; m_reload = nr; m_en = ne; m_auto = na; m_exp = nx; m_state = ns;
`endif
    endtask

    task automatic step(input logic [15:0] a, input logic [15:0] d, input logic w,
                        input logic r, input string tag);
        logic [16:0] pr;
        addr = a; dout = d; wren = w; Resetn = r;
        pr = r ? model_read(a) : 17'h10000;
        @(posedge Clock);
        #1;
        model_update(a, d, w, r);
        if (pr[16]) check({tag, ".din"}, DIN, pr[15:0]);
        check({tag, ".led"}, {6'b0, LEDR}, {6'b0, m_led});
        check({tag, ".irq"}, {15'b0, irq}, {15'b0, m_exp});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(16'h0000, 16'h0000, 1'b0, 1'b0, "rst0");
        step(16'h0000, 16'h0000, 1'b0, 1'b0, "rst1");
        check("rst.din", DIN, 16'h0000);
        check("rst.led", {6'b0, LEDR}, 16'h0000);
        check("rst.irq", {15'b0, irq}, 16'h0000);

        // RAM write, read-back latency and aliasing
        step(16'h0003, 16'h0005, 1'b1, 1'b1, "ram.wr");
        step(16'h0003, 16'h0000, 1'b0, 1'b1, "ram.rd");
        check("ram.rd.const", DIN, 16'h0005);
        step(16'h0083, 16'h0000, 1'b0, 1'b1, "ram.alias");
        check("ram.alias.const", DIN, 16'h0005);
        step(16'h0003, 16'h1234, 1'b1, 1'b1, "ram.rfirst");
        check("ram.rfirst.const", DIN, 16'h0005);
        step(16'h0003, 16'h0000, 1'b0, 1'b1, "ram.new");
        check("ram.new.const", DIN, 16'h1234);

        // LED, unmapped and switch accesses
        step(16'h1000, 16'h03FF, 1'b1, 1'b1, "led.wr");
        check("led.const", {6'b0, LEDR}, 16'h03FF);
        step(16'h5003, 16'hDEAD, 1'b1, 1'b1, "unm.wr");
        step(16'h5000, 16'h0000, 1'b0, 1'b1, "unm.rd");
        check("unm.rd.const", DIN, 16'h0000);
        SW = 10'h2A0;
        step(16'h3000, 16'hFFFF, 1'b1, 1'b1, "sw.rd");
        check("sw.rd.const", DIN, 16'h02A0);
        step(16'h0003, 16'h0000, 1'b0, 1'b1, "ram.keep");
        check("ram.keep.const", DIN, 16'h1234);
        step(16'h1000, 16'h0000, 1'b0, 1'b1, "led.rd");
        check("led.rd.const", DIN, 16'h03FF);

`ifdef MEM_IO_RESPONDER_TIMER_EN
        // one-shot countdown into STOP
        step(16'h2000, 16'h0003, 1'b1, 1'b1, "t1.cnt");
        step(16'h2001, 16'h0001, 1'b1, 1'b1, "t1.ctl");
        for (int i = 0; i < 4; i++) begin
            step(16'h2000, 16'h0000, 1'b0, 1'b1, "t1.run");
            check("t1.count", DIN, 16'(3 - i));
            check("t1.irq", {15'b0, irq}, {15'b0, (i == 3)});
        end
        step(16'h2000, 16'h0000, 1'b0, 1'b1, "t1.hold");
        check("t1.hold.const", DIN, 16'h0000);
        step(16'h2001, 16'h0000, 1'b0, 1'b1, "t1.ctrl");
        check("t1.ctrl.const", DIN, 16'h8001);
        step(16'h2001, 16'h8001, 1'b1, 1'b1, "t1.clr");
        check("t1.clr.irq", {15'b0, irq}, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step(16'h2000, 16'h0000, 1'b0, 1'b1, "t1.stop");
            check("t1.stop.irq", {15'b0, irq}, 16'h0000);
        end

        // auto-reload period and set-beats-clear
        step(16'h2001, 16'h0000, 1'b1, 1'b1, "t2.dis");
        step(16'h2000, 16'h0002, 1'b1, 1'b1, "t2.cnt");
        step(16'h2001, 16'h0003, 1'b1, 1'b1, "t2.ctl");
        step(16'h2000, 16'h0000, 1'b0, 1'b1, "t2.e1");
        check("t2.e1.irq", {15'b0, irq}, 16'h0000);
        step(16'h2000, 16'h0000, 1'b0, 1'b1, "t2.e2");
        check("t2.e2.irq", {15'b0, irq}, 16'h0000);
        step(16'h2000, 16'h0000, 1'b0, 1'b1, "t2.e3");
        check("t2.e3.irq", {15'b0, irq}, 16'h0001);
        step(16'h2001, 16'h8003, 1'b1, 1'b1, "t2.e4");
        check("t2.e4.irq", {15'b0, irq}, 16'h0000);
        step(16'h2000, 16'h0000, 1'b0, 1'b1, "t2.e5");
        check("t2.e5.irq", {15'b0, irq}, 16'h0000);
        step(16'h2001, 16'h8003, 1'b1, 1'b1, "t2.e6");
        check("t2.e6.irq", {15'b0, irq}, 16'h0001);
        step(16'h2000, 16'h0000, 1'b0, 1'b1, "t2.e7");
        check("t2.e7.count", DIN, 16'h0002);

        // RELOAD=0 with AUTO expires every cycle
        step(16'h2001, 16'h8000, 1'b1, 1'b1, "t3.dis");
        step(16'h2000, 16'h0000, 1'b1, 1'b1, "t3.cnt");
        step(16'h2001, 16'h0003, 1'b1, 1'b1, "t3.ctl");
        for (int i = 0; i < 3; i++) begin
            step(16'h2001, 16'h8003, 1'b1, 1'b1, "t3.clr");
            check("t3.irq", {15'b0, irq}, 16'h0001);
        end

        // reset in the middle of a long count
        step(16'h2001, 16'h8000, 1'b1, 1'b1, "t4.dis");
        step(16'h0010, 16'hBEEF, 1'b1, 1'b1, "t4.ram");
        step(16'h2000, 16'h00F0, 1'b1, 1'b1, "t4.cnt");
        step(16'h2001, 16'h0001, 1'b1, 1'b1, "t4.ctl");
        for (int i = 0; i < 5; i++) step(16'h2000, 16'h0000, 1'b0, 1'b1, "t4.run");
        step(16'h2000, 16'h0000, 1'b0, 1'b0, "t4.rst");
        check("t4.rst.din", DIN, 16'h0000);
        check("t4.rst.led", {6'b0, LEDR}, 16'h0000);
        check("t4.rst.irq", {15'b0, irq}, 16'h0000);
        step(16'h2000, 16'h0000, 1'b0, 1'b1, "t4.rdcnt");
        check("t4.count", DIN, 16'h0000);
        step(16'h2001, 16'h0000, 1'b0, 1'b1, "t4.rdctl");
        check("t4.ctrl", DIN, 16'h0000);
        step(16'h2000, 16'h0000, 1'b0, 1'b1, "t4.idle");
        check("t4.idle.count", DIN, 16'h0000);
        step(16'h0010, 16'h0000, 1'b0, 1'b1, "t4.ramrd");
        check("t4.ram.const", DIN, 16'hBEEF);
`else
        step(16'h2000, 16'h1234, 1'b1, 1'b1, "nt.wr");
        step(16'h2000, 16'h0000, 1'b0, 1'b1, "nt.rd");
        check("nt.rd.const", DIN, 16'h0000);
        check("nt.irq.const", {15'b0, irq}, 16'h0000);
`endif

        for (int i = 0; i < 500; i++) begin
            int          sel;
            logic [15:0] a;
            logic [15:0] d;
            logic        w;
            logic        r;
            sel = $urandom_range(0, 9);
            d = 16'($urandom);
            w = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 59) != 0);
            case (sel)
                0, 1, 2: a = 16'($urandom) & 16'h0FFF;
                3:       a = 16'h1000;
                4: begin a = 16'h2000; d = 16'($urandom_range(0, 6)); end
                5: begin a = 16'h2001; d = 16'($urandom) & 16'h8003; end
                6:       a = 16'h3000;
                7:       a = {4'($urandom_range(4, 15)), 12'($urandom)};
                8:       a = 16'h2000 | 16'($urandom_range(2, 5));
                default: a = 16'($urandom_range(0, 7));
            endcase
            if (!r) w = 1'b0;
            if (i % 50 == 0) SW = 10'($urandom);
            step(a, d, w, r, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
